cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Sequencer for the 256-entry direct-mapped read cache, placed between the CPU bus master and the memory bus. It clears all tags after reset and serves CPU requests. Cacheable word reads get a lookup: a hit is answered from the cache, a miss is fetched from memory and written back into the cache. Writes and uncacheable reads pass through to memory, and every write invalidates the matching cache line.

## Interface
- `CLEAR_CYCLES`, default 256: number of cycles the cache reset is held; must be ≥ the cache's entry count.
- `I_clk` in, 1 bit: clock.
- `I_reset_n` in, 1 bit: asynchronous, active-low reset.
- `I_cpu_stb` in, 1 bit: CPU request; held until `O_cpu_ack`.
- `I_cpu_busop` in, 3 bits: `BUSOP_*` code, stable while `I_cpu_stb` is high.
- `I_cpu_addr` in, 32 bits: request address.
- `I_cpu_data` in, 32 bits: write data.
- `O_cpu_ack` out, 1 bit: one-cycle completion pulse.
- `O_cpu_data` out, 32 bits: read data, valid while `O_cpu_ack` is high.
- `O_ready` out, 1 bit: low during tag clear.
- `O_mem_stb` out, 1 bit: memory request, held until `I_mem_ack`.
- `O_mem_busop` out, 3 bits: memory bus operation.
- `O_mem_addr` out, 32 bits: memory address.
- `O_mem_data` out, 32 bits: memory write data.
- `I_mem_ack` in, 1 bit: one-cycle memory completion.
- `I_mem_data` in, 32 bits: memory read data.
- `O_cache_en`, `O_cache_reset`, `O_cache_offer` out, 1 bit each: cache enable, tag-clear reset, and fill-data offer.
- `O_cache_busop` out, 3 bits: cache bus operation.
- `O_cache_addr`, `O_cache_inval_addr`, `O_cache_data` out, 32 bits each: lookup/fill address, invalidate address, fill data.
- `I_cache_hit` in, 1 bit: combinational hit, valid the cycle after an enabled lookup.
- `I_cache_data` in, 32 bits: registered cache read data.
- `O_hit_count`, `O_miss_count` out, 32 bits each: wrapping statistics counters.

## Operation
- States: CLEAR, IDLE, LOOKUP, MEM, FILL, ACK.
- Cacheable request: `busop == BUSOP_READW`, `addr[31:25] == 0` and `addr[1:0] == 0`.
- **CLEAR**
  - `O_cache_reset` = 1; an 8-bit counter runs 0 to `CLEAR_CYCLES`-1.
  - At terminal count, go to IDLE. `O_ready` = 1 in every state except CLEAR.
- **IDLE**
  - `O_cache_addr` = `I_cpu_addr` and `O_cache_busop` = `BUSOP_READW` (combinational).
  - `O_cache_en` = `I_cpu_stb` & cacheable.
  - Request latched. Cacheable → LOOKUP; any other request → MEM.
- **LOOKUP**
  - Cache address and busop come from the latch; `O_cache_en` = 0.
  - Hit: register `I_cache_data` into `O_cpu_data`, increment `O_hit_count`, go to ACK.
  - Miss: increment `O_miss_count`, go to MEM.
- **MEM**
  - `O_mem_stb` = 1, with busop, address and data from the latch.
  - On `I_mem_ack`: capture `I_mem_data`.
    - Cacheable read → FILL.
    - Otherwise → ACK, with `O_cpu_data` = `I_mem_data` for reads.
  - In the same cycle as `I_mem_ack`, a write drives `O_cache_busop` = the write op and `O_cache_inval_addr` = the latched address, for exactly that one cycle.
- **FILL**
  - `O_cache_en` = `O_cache_offer` = 1, `O_cache_busop` = `BUSOP_READW`, `O_cache_data` = the captured word.
  - `O_cpu_ack` = 1 with that word. Next state IDLE.
- **ACK**: `O_cpu_ack` = 1. Next state IDLE.
- Outside the cases above:
  - `O_cache_busop` = `BUSOP_NONE`.
  - `O_cache_en`, `O_cache_offer` and `O_mem_stb` are 0.
- `I_mem_ack` outside MEM is ignored.
- If `I_cpu_stb` is high in IDLE the cycle after an ack, it is a new request.
- Counters wrap at 2^32 and are cleared only by reset.

## Timing
- **Reset values:**
  - State CLEAR, counter 0.
  - `O_cache_reset` = 1.
  - All acks, strobes and enables 0.
  - All data and address outputs 0.
  - `O_ready` = 0.
  - Both counters 0.
- **Reset mid-operation:** an outstanding memory strobe is dropped at once and the clear restarts. A late `I_mem_ack` is ignored.
- **Clear length:** `O_cache_reset` is high for exactly `CLEAR_CYCLES` clock edges after reset release. The first request is accepted in the following cycle.
- **Hit:** stb sampled in IDLE at cycle n; LOOKUP at n+1; `O_cpu_ack` at n+2.
- **Miss:** stb at n; LOOKUP at n+1; MEM from n+2 until ack at cycle m; FILL with `O_cpu_ack` at m+1.
- **Pass-through:** stb at n; MEM from n+1; `O_cpu_ack` one cycle after `I_mem_ack`.
- **Immediate memory ack:** `I_mem_ack` in the first MEM cycle is legal.

## Structure
- `BUSOP_*` codes come from the shared bus definitions include.
- Add to the same shared include:
  - `CACHE_TOP_BITS` = 7: width of `addr[31:25]`, which must be zero for cacheable requests.
  - The state encoding.
- One sub-module, `cache_ctrl_stats`, holds the two counters with increment inputs.
- The cache itself is instantiated by the parent, not inside this block.

## Test plan
- **Reset release:** `O_cache_reset` is high for 256 cycles and `O_ready` rises on cycle 257. A stb raised during CLEAR is not acked until after the clear.
- **Miss then hit:** READW at 0x100 with memory returning 0xDEADBEEF.
  - First access: miss, one memory read, FILL offers 0xDEADBEEF, `O_miss_count` = 1.
  - Second access: ack at n+2 with 0xDEADBEEF, no `O_mem_stb`, `O_hit_count` = 1.
- **Write invalidates:** WRITEW 0x100 ← 0x12345678.
  - `O_cache_busop` = WRITEW for exactly one cycle, with `O_cache_inval_addr` = 0x100.
  - The next READW 0x100 misses and refills.
- **Uncacheable reads:** READW 0x02000000 and READB 0x101 both go to memory, issue no cache enable, and return memory data.
- **Reset mid-miss:** assert `I_reset_n` = 0 during MEM. `O_mem_stb` drops immediately, counters read 0 and CLEAR restarts.
- **Back-to-back hits:** stb held across an ack. The second request's ack arrives 3 cycles after the first.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared bus definitions for the read-cache sequencer: bus operation codes,
// cacheable-window width, sequencer state encoding and request classifiers.
package cache_ctrl_pkg;

  localparam logic [2:0] BUSOP_NONE   = 3'd0;
  localparam logic [2:0] BUSOP_READB  = 3'd1;
  localparam logic [2:0] BUSOP_READH  = 3'd2;
  localparam logic [2:0] BUSOP_READW  = 3'd3;
  localparam logic [2:0] BUSOP_WRITEB = 3'd5;
  localparam logic [2:0] BUSOP_WRITEH = 3'd6;
  localparam logic [2:0] BUSOP_WRITEW = 3'd7;

  // Width of addr[31:25]; only the low 32 MiB window is cacheable.
  localparam int unsigned CACHE_TOP_BITS = 7;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StLookup,
    StMem,
    StFill,
    StAck
  } state_e;

  function automatic logic is_write(input logic [2:0] busop);
    return busop[2];
  endfunction

  function automatic logic is_read(input logic [2:0] busop);
    return (busop != BUSOP_NONE) && !busop[2];
  endfunction

  function automatic logic is_cacheable(input logic [2:0] busop, input logic [31:0] addr);
    return (busop == BUSOP_READW) && (addr[31:32-CACHE_TOP_BITS] == '0) &&
           (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/cache_ctrl_stats.sv
// Hit/miss statistics for the cache sequencer; free-running wrapping counters
// cleared only by reset.
module cache_ctrl_stats (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_hit_inc,
  input  logic        I_miss_inc,
  output logic [31:0] O_hit_count,
  output logic [31:0] O_miss_count
);

  logic [31:0] hit_q, miss_q;

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (I_hit_inc)  hit_q  <= hit_q + 32'd1;
      if (I_miss_inc) miss_q <= miss_q + 32'd1;
    end
  end

  assign O_hit_count  = hit_q;
  assign O_miss_count = miss_q;

endmodule

// File: rtl/cache_ctrl.sv
// Sequencer between the CPU bus master, the memory bus and a 256-entry
// direct-mapped read cache: tag clear after reset, lookup, refill, pass-through.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 256
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_cpu_stb,
  input  logic [2:0]  I_cpu_busop,
  input  logic [31:0] I_cpu_addr,
  input  logic [31:0] I_cpu_data,
  output logic        O_cpu_ack,
  output logic [31:0] O_cpu_data,
  output logic        O_ready,
  output logic        O_mem_stb,
  output logic [2:0]  O_mem_busop,
  output logic [31:0] O_mem_addr,
  output logic [31:0] O_mem_data,
  input  logic        I_mem_ack,
  input  logic [31:0] I_mem_data,
  output logic        O_cache_en,
  output logic        O_cache_reset,
  output logic        O_cache_offer,
  output logic [2:0]  O_cache_busop,
  output logic [31:0] O_cache_addr,
  output logic [31:0] O_cache_inval_addr,
  output logic [31:0] O_cache_data,
  input  logic        I_cache_hit,
  input  logic [31:0] I_cache_data,
  output logic [31:0] O_hit_count,
  output logic [31:0] O_miss_count
);

  localparam logic [7:0] ClrLast = 8'(CLEAR_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  clr_cnt_q, clr_cnt_d;
  logic [2:0]  busop_q, busop_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic        cacheable_q, cacheable_d;
  logic        hit_inc, miss_inc;
  logic        req_cacheable;

  assign req_cacheable = is_cacheable(I_cpu_busop, I_cpu_addr);

  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q     <= StClear;
      clr_cnt_q   <= '0;
      busop_q     <= BUSOP_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      cacheable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      busop_q     <= busop_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      data_q      <= data_d;
      cacheable_q <= cacheable_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    busop_d       = busop_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    data_d        = data_q;
    cacheable_d   = cacheable_q;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    O_cpu_ack     = 1'b0;
    O_ready       = 1'b1;
    O_mem_stb     = 1'b0;
    O_cache_en    = 1'b0;
    O_cache_reset = 1'b0;
    O_cache_offer = 1'b0;
    O_cache_busop = BUSOP_NONE;
    O_cache_addr  = addr_q;

    unique case (state_q)
      StClear: begin
        O_cache_reset = 1'b1;
        O_ready       = 1'b0;
        if (clr_cnt_q == ClrLast) begin
          clr_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          clr_cnt_d = clr_cnt_q + 8'd1;
        end
      end
      StIdle: begin
        // Lookup is issued straight from the CPU bus so the hit is ready in LOOKUP.
        O_cache_addr  = I_cpu_addr;
        O_cache_busop = BUSOP_READW;
        O_cache_en    = I_cpu_stb & req_cacheable;
        if (I_cpu_stb) begin
          busop_d     = I_cpu_busop;
          addr_d      = I_cpu_addr;
          wdata_d     = I_cpu_data;
          cacheable_d = req_cacheable;
          state_d     = req_cacheable ? StLookup : StMem;
        end
      end
      StLookup: begin
        O_cache_busop = busop_q;
        if (I_cache_hit) begin
          data_d  = I_cache_data;
          hit_inc = 1'b1;
          state_d = StAck;
        end else begin
          miss_inc = 1'b1;
          state_d  = StMem;
        end
      end
      StMem: begin
        O_mem_stb = 1'b1;
        if (I_mem_ack) begin
          if (cacheable_q) begin
            data_d  = I_mem_data;
            state_d = StFill;
          end else begin
            if (is_read(busop_q)) data_d = I_mem_data;
            // Single-cycle invalidate of the written line, aligned with the memory ack.
            if (is_write(busop_q)) O_cache_busop = busop_q;
            state_d = StAck;
          end
        end
      end
      StFill: begin
        O_cache_en    = 1'b1;
        O_cache_offer = 1'b1;
        O_cache_busop = BUSOP_READW;
        O_cpu_ack     = 1'b1;
        state_d       = StIdle;
      end
      StAck: begin
        O_cpu_ack = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StClear;
    endcase
  end

  assign O_cpu_data         = data_q;
  assign O_cache_data       = data_q;
  assign O_mem_busop        = busop_q;
  assign O_mem_addr         = addr_q;
  assign O_mem_data         = wdata_q;
  assign O_cache_inval_addr = addr_q;

  cache_ctrl_stats u_stats (
    .I_clk       (I_clk),
    .I_reset_n   (I_reset_n),
    .I_hit_inc   (hit_inc),
    .I_miss_inc  (miss_inc),
    .O_hit_count (O_hit_count),
    .O_miss_count(O_miss_count)
  );

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural direct-mapped cache and a
// memory responder with programmable ack delay.
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_stb = 1'b0;
  logic [2:0]  cpu_busop = BUSOP_NONE;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        O_cpu_ack, O_ready, O_mem_stb;
  logic [31:0] O_cpu_data, O_mem_addr, O_mem_data;
  logic [2:0]  O_mem_busop, O_cache_busop;
  logic        I_mem_ack = 1'b0;
  logic [31:0] I_mem_data = '0;
  logic        O_cache_en, O_cache_reset, O_cache_offer;
  logic [31:0] O_cache_addr, O_cache_inval_addr, O_cache_data;
  logic        c_hit = 1'b0;
  logic [31:0] c_data = '0;
  logic [31:0] O_hit_count, O_miss_count;

  int errors = 0;
  int checks = 0;

  // Memory responder controls and observations
  bit          mem_enable = 1'b1;
  bit          late_ack = 1'b0;
  int          mem_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_wdata = '0;
  int          mem_txn = 0;

  // Negedge monitors
  int          stb_cycles = 0;
  int          en_cycles = 0;
  int          inval_cycles = 0;
  logic [31:0] inval_addr = '0;

  // Behavioural cache: index addr[9:2], tag addr[24:10]
  logic        valid_m [256];
  logic [14:0] tag_m   [256];
  logic [31:0] data_m  [256];

  always #5 clk = ~clk;

  cache_ctrl #(
    .CLEAR_CYCLES(256)
  ) dut (
    .I_clk             (clk),
    .I_reset_n         (rst_n),
    .I_cpu_stb         (cpu_stb),
    .I_cpu_busop       (cpu_busop),
    .I_cpu_addr        (cpu_addr),
    .I_cpu_data        (cpu_wdata),
    .O_cpu_ack         (O_cpu_ack),
    .O_cpu_data        (O_cpu_data),
    .O_ready           (O_ready),
    .O_mem_stb         (O_mem_stb),
    .O_mem_busop       (O_mem_busop),
    .O_mem_addr        (O_mem_addr),
    .O_mem_data        (O_mem_data),
    .I_mem_ack         (I_mem_ack),
    .I_mem_data        (I_mem_data),
    .O_cache_en        (O_cache_en),
    .O_cache_reset     (O_cache_reset),
    .O_cache_offer     (O_cache_offer),
    .O_cache_busop     (O_cache_busop),
    .O_cache_addr      (O_cache_addr),
    .O_cache_inval_addr(O_cache_inval_addr),
    .O_cache_data      (O_cache_data),
    .I_cache_hit       (c_hit),
    .I_cache_data      (c_data),
    .O_hit_count       (O_hit_count),
    .O_miss_count      (O_miss_count)
  );

  always @(posedge clk) begin
    if (O_cache_reset) begin
      for (int i = 0; i < 256; i++) valid_m[i] <= 1'b0;
    end else begin
      if (O_cache_en && !O_cache_offer) begin
        c_hit  <= valid_m[O_cache_addr[9:2]] && (tag_m[O_cache_addr[9:2]] == O_cache_addr[24:10]);
        c_data <= data_m[O_cache_addr[9:2]];
      end
      if (O_cache_en && O_cache_offer) begin
        valid_m[O_cache_addr[9:2]] <= 1'b1;
        tag_m[O_cache_addr[9:2]]   <= O_cache_addr[24:10];
        data_m[O_cache_addr[9:2]]  <= O_cache_data;
      end
      if (O_cache_busop[2]) valid_m[O_cache_inval_addr[9:2]] <= 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (!mem_enable) begin
      I_mem_ack = late_ack;
      wait_cnt  = 0;
    end else if (I_mem_ack) begin
      I_mem_ack = 1'b0;
    end else if (O_mem_stb) begin
      if (wait_cnt == mem_delay) begin
        I_mem_ack  = 1'b1;
        I_mem_data = mem_rdata;
        wait_cnt   = 0;
        mem_txn++;
        if (O_mem_busop[2]) mem_wdata = O_mem_data;
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (O_mem_stb) stb_cycles++;
    if (O_cache_en) en_cycles++;
    if (O_cache_busop == BUSOP_WRITEW) begin
      inval_cycles++;
      inval_addr = O_cache_inval_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    tick();
    cpu_stb   = 1'b1;
    cpu_busop = op;
    cpu_addr  = addr;
    cpu_wdata = wd;
  endtask

  task automatic end_req();
    tick();
    cpu_stb   = 1'b0;
    cpu_busop = BUSOP_NONE;
  endtask

  // k counts negedges after the one that follows the call
  task automatic wait_ack(input int max, output int k, output bit timeout);
    k = 0;
    @(negedge clk);
    while (!O_cpu_ack && k < max) begin
      @(negedge clk);
      k++;
    end
    timeout = !O_cpu_ack;
  endtask

  task automatic test_reset();
    int k, clr, early, n;
    bit to;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({O_cache_reset, O_ready, O_cpu_ack, O_mem_stb, O_cache_en, O_cache_offer} !== 6'b100000)
    begin
      errors++;
      $display("FAIL reset_flags: got %b expected 100000",
               {O_cache_reset, O_ready, O_cpu_ack, O_mem_stb, O_cache_en, O_cache_offer});
    end
    checks++;
    if ({O_hit_count, O_miss_count} !== 64'd0) begin
      errors++;
      $display("FAIL reset_counters: got %h/%h expected 0/0", O_hit_count, O_miss_count);
    end
    checks++;
    if ({O_cpu_data, O_mem_addr, O_mem_data, O_cache_addr, O_cache_data} !== 160'd0) begin
      errors++;
      $display("FAIL reset_data: got cpu %h maddr %h mdata %h caddr %h cdata %h expected 0",
               O_cpu_data, O_mem_addr, O_mem_data, O_cache_addr, O_cache_data);
    end
    checks++;
    if (O_mem_busop !== BUSOP_NONE || O_cache_busop !== BUSOP_NONE) begin
      errors++;
      $display("FAIL reset_busop: got %0d/%0d expected 0/0", O_mem_busop, O_cache_busop);
    end
    // Release reset with a cacheable request already pending
    tick();
    rst_n     = 1'b1;
    mem_delay = 0;
    mem_rdata = 32'hA5A5_0001;
    cpu_stb   = 1'b1;
    cpu_busop = BUSOP_READW;
    cpu_addr  = 32'h0000_0040;
    clr = 0; early = 0; n = 0;
    @(negedge clk);
    while (O_cache_reset && n < 400) begin
      clr++;
      if (O_cpu_ack) early++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (clr != 256) begin
      errors++;
      $display("FAIL clear_length: got %0d expected 256", clr);
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL ack_during_clear: got %0d expected 0", early);
    end
    checks++;
    if (O_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_clear: got %b expected 1", O_ready);
    end
    wait_ack(20, k, to);
    checks++;
    if (to || k != 2) begin
      errors++;
      $display("FAIL first_req_latency: got %0d (timeout %0d) expected 2", k, to);
    end
    checks++;
    if (O_cpu_data !== 32'hA5A5_0001 || O_miss_count !== 32'd1) begin
      errors++;
      $display("FAIL first_req_data: got %h miss %0d expected a5a50001 miss 1",
               O_cpu_data, O_miss_count);
    end
    end_req();
  endtask

  task automatic test_miss_then_hit();
    int k, txn0, s0;
    bit to;
    mem_delay = 2;
    mem_rdata = 32'hDEAD_BEEF;
    txn0 = mem_txn;
    start_req(BUSOP_READW, 32'h0000_0100, 32'h0);
    wait_ack(30, k, to);
    checks++;
    if (to || k != 5) begin
      errors++;
      $display("FAIL miss_latency: got %0d (timeout %0d) expected 5", k, to);
    end
    checks++;
    if ({O_cache_en, O_cache_offer} !== 2'b11 || O_cache_busop !== BUSOP_READW ||
        O_cache_data !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL fill_offer: got en %b offer %b op %0d data %h expected 1 1 3 deadbeef",
               O_cache_en, O_cache_offer, O_cache_busop, O_cache_data);
    end
    checks++;
    if (O_cpu_data !== 32'hDEAD_BEEF || mem_txn - txn0 != 1 || O_miss_count !== 32'd2) begin
      errors++;
      $display("FAIL miss_result: got data %h txns %0d miss %0d expected deadbeef 1 2",
               O_cpu_data, mem_txn - txn0, O_miss_count);
    end
    end_req();
    s0 = stb_cycles;
    start_req(BUSOP_READW, 32'h0000_0100, 32'h0);
    wait_ack(20, k, to);
    checks++;
    if (to || k != 2) begin
      errors++;
      $display("FAIL hit_latency: got %0d (timeout %0d) expected 2", k, to);
    end
    checks++;
    if (O_cpu_data !== 32'hDEAD_BEEF || stb_cycles != s0 || O_hit_count !== 32'd1) begin
      errors++;
      $display("FAIL hit_result: got data %h mem_stb_cycles %0d hit %0d expected deadbeef 0 1",
               O_cpu_data, stb_cycles - s0, O_hit_count);
    end
    end_req();
  endtask

  task automatic test_write_inval();
    int k, i0;
    bit to;
    mem_delay = 1;
    i0 = inval_cycles;
    start_req(BUSOP_WRITEW, 32'h0000_0100, 32'h1234_5678);
    wait_ack(20, k, to);
    checks++;
    if (to || k != 3) begin
      errors++;
      $display("FAIL write_latency: got %0d (timeout %0d) expected 3", k, to);
    end
    checks++;
    if (inval_cycles - i0 != 1 || inval_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL write_inval: got cycles %0d addr %h expected 1 00000100",
               inval_cycles - i0, inval_addr);
    end
    checks++;
    if (mem_wdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_data: got %h expected 12345678", mem_wdata);
    end
    end_req();
    mem_delay = 0;
    mem_rdata = 32'h1234_5678;
    start_req(BUSOP_READW, 32'h0000_0100, 32'h0);
    wait_ack(20, k, to);
    checks++;
    if (to || k != 3 || O_cpu_data !== 32'h1234_5678 || O_miss_count !== 32'd3) begin
      errors++;
      $display("FAIL refill_after_write: got k %0d data %h miss %0d expected 3 12345678 3",
               k, O_cpu_data, O_miss_count);
    end
    end_req();
  endtask

  task automatic test_uncacheable();
    int k, e0;
    bit to;
    e0 = en_cycles;
    mem_delay = 0;
    mem_rdata = 32'hCAFE_0001;
    start_req(BUSOP_READW, 32'h0200_0000, 32'h0);
    wait_ack(20, k, to);
    checks++;
    if (to || k != 2 || O_cpu_data !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL uncached_high: got k %0d data %h expected 2 cafe0001", k, O_cpu_data);
    end
    end_req();
    mem_rdata = 32'h0000_00AB;
    start_req(BUSOP_READB, 32'h0000_0101, 32'h0);
    wait_ack(20, k, to);
    checks++;
    if (to || k != 2 || O_cpu_data !== 32'h0000_00AB) begin
      errors++;
      $display("FAIL uncached_byte: got k %0d data %h expected 2 000000ab", k, O_cpu_data);
    end
    end_req();
    checks++;
    if (en_cycles != e0 || O_hit_count !== 32'd1 || O_miss_count !== 32'd3) begin
      errors++;
      $display("FAIL uncached_side: got en %0d hit %0d miss %0d expected 0 1 3",
               en_cycles - e0, O_hit_count, O_miss_count);
    end
  endtask

  task automatic test_back_to_back();
    int k1, k2;
    bit to1, to2;
    start_req(BUSOP_READW, 32'h0000_0100, 32'h0);
    wait_ack(20, k1, to1);
    checks++;
    if (to1 || k1 != 2 || O_cpu_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL b2b_first: got k %0d data %h expected 2 12345678", k1, O_cpu_data);
    end
    wait_ack(20, k2, to2);
    checks++;
    if (to2 || k2 != 2 || O_cpu_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL b2b_second: got gap %0d data %h expected 3 12345678", k2 + 1, O_cpu_data);
    end
    checks++;
    if (O_hit_count !== 32'd3) begin
      errors++;
      $display("FAIL b2b_hits: got %0d expected 3", O_hit_count);
    end
    end_req();
  endtask

  task automatic test_reset_mid_miss();
    int k, n, clr, stb_seen;
    bit to;
    mem_enable = 1'b0;
    late_ack   = 1'b0;
    start_req(BUSOP_READW, 32'h0000_0300, 32'h0);
    n = 0;
    @(negedge clk);
    while (!O_mem_stb && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (O_mem_stb !== 1'b1) begin
      errors++;
      $display("FAIL mid_miss_stb: got %b expected 1", O_mem_stb);
    end
    rst_n   = 1'b0;
    cpu_stb = 1'b0;
    #1;
    checks++;
    if (O_mem_stb !== 1'b0 || O_cache_reset !== 1'b1 || O_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_flags: got stb %b creset %b ready %b expected 0 1 0",
               O_mem_stb, O_cache_reset, O_ready);
    end
    checks++;
    if (O_hit_count !== 32'd0 || O_miss_count !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_counters: got %0d/%0d expected 0/0", O_hit_count, O_miss_count);
    end
    late_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    clr = 0; stb_seen = 0; n = 0;
    @(negedge clk);
    while (O_cache_reset && n < 400) begin
      clr++;
      if (O_mem_stb || O_cpu_ack) stb_seen++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (clr != 256 || stb_seen != 0) begin
      errors++;
      $display("FAIL clear_restart: got length %0d stray %0d expected 256 0", clr, stb_seen);
    end
    late_ack   = 1'b0;
    mem_enable = 1'b1;
    mem_rdata  = 32'h0BAD_F00D;
    start_req(BUSOP_READW, 32'h0000_0300, 32'h0);
    wait_ack(20, k, to);
    checks++;
    if (to || k != 3 || O_cpu_data !== 32'h0BAD_F00D || O_miss_count !== 32'd1) begin
      errors++;
      $display("FAIL after_mid_reset: got k %0d data %h miss %0d expected 3 0badf00d 1",
               k, O_cpu_data, O_miss_count);
    end
    end_req();
  endtask

  initial begin
    test_reset();
    test_miss_then_hit();
    test_write_inval();
    test_uncacheable();
    test_back_to_back();
    test_reset_mid_miss();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
